d_ex_pipe: RTL and testbench

ID/EX pipeline boundary of the five-stage MIPS core. It registers the decode-stage control bundle (regdst, branch, memread, memtoreg, memwrite, alusrc, regwrite, aluop, other) together with the operand data and register fields, and presents them to the execute stage one cycle later. It also contains the load-use hazard detector, which stalls fetch/decode and inserts a bubble. It handles the branch flush and keeps saturating counters of bubbles and flushes for performance debug.

---
 rtl/d_pipe_pkg.sv | 24 ++
 rtl/d_hazard_detect.sv | 28 ++
 rtl/d_ex_pipe.sv | 108 ++++++++++
 tb/tb_d_ex_pipe.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/d_pipe_pkg.sv
// Shared types for the ID/EX boundary: the decode control bundle, its NOP value
// and the ALU operation class encodings.
package d_pipe_pkg;

    typedef struct packed {
        logic       regdst;
        logic       branch;
        logic       memread;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regwrite;
        logic [1:0] aluop;
        logic [3:0] other;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_IMM    = 2'b11;

endpackage

// File: rtl/d_hazard_detect.sv
// Load-use hazard detector: purely combinational, compares the load sitting in
// EX against the source registers of the instruction in ID.
module d_hazard_detect (
    input  logic       ex_valid_i,
    input  logic       ex_memread_i,
    input  logic [4:0] ex_rt_i,
    input  logic       id_valid_i,
    input  logic       id_alusrc_i,
    input  logic       id_memwrite_i,
    input  logic       id_branch_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       flush_i,
    output logic       hz_o,
    output logic       stall_o
);

    logic id_uses_rt;

    // rt is a source for R-type, stores and branches; for immediates it is the destination
    assign id_uses_rt = ~id_alusrc_i | id_memwrite_i | id_branch_i;

    assign hz_o = ex_valid_i & ex_memread_i & (ex_rt_i != 5'd0) &
                  ((ex_rt_i == id_rs_i) | (id_uses_rt & (ex_rt_i == id_rt_i)));

    assign stall_o = id_valid_i & hz_o & ~flush_i;

endmodule

// File: rtl/d_ex_pipe.sv
// ID/EX pipeline register with load-use stall, branch flush and saturating
// bubble/flush counters; one cycle of latency from ID inputs to EX outputs.
module d_ex_pipe
    import d_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_id_valid,
    input  ctrl_t             i_id_ctrl,
    input  logic [4:0]        i_id_rs,
    input  logic [4:0]        i_id_rt,
    input  logic [4:0]        i_id_rd,
    input  logic [DATA_W-1:0] i_id_rdata1,
    input  logic [DATA_W-1:0] i_id_rdata2,
    input  logic [DATA_W-1:0] i_id_imm,
    input  logic [DATA_W-1:0] i_id_pc4,
    input  logic              i_flush,
    output logic              o_stall,
    output logic              o_ex_valid,
    output ctrl_t             o_ex_ctrl,
    output logic [4:0]        o_ex_rs,
    output logic [4:0]        o_ex_rt,
    output logic [4:0]        o_ex_rd,
    output logic [DATA_W-1:0] o_ex_rdata1,
    output logic [DATA_W-1:0] o_ex_rdata2,
    output logic [DATA_W-1:0] o_ex_imm,
    output logic [DATA_W-1:0] o_ex_pc4,
    output logic [CNT_W-1:0]  o_bubble_cnt,
    output logic [CNT_W-1:0]  o_flush_cnt
);

    logic              valid_q;
    ctrl_t             ctrl_q;
    logic [4:0]        rs_q, rt_q, rd_q;
    logic [DATA_W-1:0] rdata1_q, rdata2_q, imm_q, pc4_q;
    logic [CNT_W-1:0]  bubble_cnt_q, flush_cnt_q;
    logic              hz;
    logic              stall;

    d_hazard_detect u_hazard (
        .ex_valid_i    (valid_q),
        .ex_memread_i  (ctrl_q.memread),
        .ex_rt_i       (rt_q),
        .id_valid_i    (i_id_valid),
        .id_alusrc_i   (i_id_ctrl.alusrc),
        .id_memwrite_i (i_id_ctrl.memwrite),
        .id_branch_i   (i_id_ctrl.branch),
        .id_rs_i       (i_id_rs),
        .id_rt_i       (i_id_rt),
        .flush_i       (i_flush),
        .hz_o          (hz),
        .stall_o       (stall)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_q      <= 1'b0;
            ctrl_q       <= CTRL_NOP;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            rdata1_q     <= '0;
            rdata2_q     <= '0;
            imm_q        <= '0;
            pc4_q        <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else if (i_flush) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_NOP;
            if (flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end else if (stall) begin
            // Bubble: data/field registers hold so the load stays visible to forwarding
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_NOP;
            if (bubble_cnt_q != '1)
                bubble_cnt_q <= bubble_cnt_q + 1'b1;
        end else begin
            valid_q  <= i_id_valid;
            ctrl_q   <= i_id_valid ? i_id_ctrl : CTRL_NOP;
            rs_q     <= i_id_rs;
            rt_q     <= i_id_rt;
            rd_q     <= i_id_rd;
            rdata1_q <= i_id_rdata1;
            rdata2_q <= i_id_rdata2;
            imm_q    <= i_id_imm;
            pc4_q    <= i_id_pc4;
        end
    end

    assign o_stall      = stall;
    assign o_ex_valid   = valid_q;
    assign o_ex_ctrl    = ctrl_q;
    assign o_ex_rs      = rs_q;
    assign o_ex_rt      = rt_q;
    assign o_ex_rd      = rd_q;
    assign o_ex_rdata1  = rdata1_q;
    assign o_ex_rdata2  = rdata2_q;
    assign o_ex_imm     = imm_q;
    assign o_ex_pc4     = pc4_q;
    assign o_bubble_cnt = bubble_cnt_q;
    assign o_flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_d_ex_pipe.sv
// Directed bench for d_ex_pipe with 4-bit counters so saturation is reachable.
module tb_d_ex_pipe;
    import d_pipe_pkg::*;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    // bit order: regdst branch memread memtoreg memwrite alusrc regwrite aluop[1:0] other[3:0]
    localparam ctrl_t C_ADDI = ctrl_t'(13'b0_0_0_0_0_1_1_11_0000);
    localparam ctrl_t C_LW   = ctrl_t'(13'b0_0_1_1_0_1_1_00_0000);
    localparam ctrl_t C_ADD  = ctrl_t'(13'b1_0_0_0_0_0_1_10_0000);
    localparam ctrl_t C_SW   = ctrl_t'(13'b0_0_0_0_1_1_0_00_0000);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              id_valid;
    ctrl_t             id_ctrl;
    logic [4:0]        id_rs, id_rt, id_rd;
    logic [DATA_W-1:0] id_rdata1, id_rdata2, id_imm, id_pc4;
    logic              flush;
    logic              stall;
    logic              ex_valid;
    ctrl_t             ex_ctrl;
    logic [4:0]        ex_rs, ex_rt, ex_rd;
    logic [DATA_W-1:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc4;
    logic [CNT_W-1:0]  bubble_cnt, flush_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    d_ex_pipe #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_id_valid   (id_valid),
        .i_id_ctrl    (id_ctrl),
        .i_id_rs      (id_rs),
        .i_id_rt      (id_rt),
        .i_id_rd      (id_rd),
        .i_id_rdata1  (id_rdata1),
        .i_id_rdata2  (id_rdata2),
        .i_id_imm     (id_imm),
        .i_id_pc4     (id_pc4),
        .i_flush      (flush),
        .o_stall      (stall),
        .o_ex_valid   (ex_valid),
        .o_ex_ctrl    (ex_ctrl),
        .o_ex_rs      (ex_rs),
        .o_ex_rt      (ex_rt),
        .o_ex_rd      (ex_rd),
        .o_ex_rdata1  (ex_rdata1),
        .o_ex_rdata2  (ex_rdata2),
        .o_ex_imm     (ex_imm),
        .o_ex_pc4     (ex_pc4),
        .o_bubble_cnt (bubble_cnt),
        .o_flush_cnt  (flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input ctrl_t c, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] r1, input logic [31:0] r2,
                          input logic [31:0] imm, input logic [31:0] pc4);
        id_valid  = v;
        id_ctrl   = c;
        id_rs     = rs;
        id_rt     = rt;
        id_rd     = rd;
        id_rdata1 = r1;
        id_rdata2 = r2;
        id_imm    = imm;
        id_pc4    = pc4;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        set_id(1'b0, CTRL_NOP, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);

        // reset state
        tick();
        tick();
        chk("rst_valid", {31'b0, ex_valid}, 32'd0);
        chk("rst_ctrl", {19'b0, ex_ctrl}, 32'd0);
        chk("rst_rdata1", ex_rdata1, 32'd0);
        chk("rst_bubble_cnt", {28'b0, bubble_cnt}, 32'd0);
        chk("rst_flush_cnt", {28'b0, flush_cnt}, 32'd0);
        rst_n = 1'b1;

        // basic load of an addi
        set_id(1'b1, C_ADDI, 5'd1, 5'd2, 5'd0, 32'h10, 32'h22, 32'h4, 32'h104);
        chk("basic_stall_id", {31'b0, stall}, 32'd0);
        tick();
        chk("basic_valid", {31'b0, ex_valid}, 32'd1);
        chk("basic_ctrl", {19'b0, ex_ctrl}, {19'b0, C_ADDI});
        chk("basic_rdata1", ex_rdata1, 32'h10);
        chk("basic_rt", {27'b0, ex_rt}, 32'd2);
        chk("basic_imm", ex_imm, 32'h4);
        chk("basic_pc4", ex_pc4, 32'h104);

        // load-use on rs
        set_id(1'b1, C_LW, 5'd1, 5'd5, 5'd0, 32'h30, 32'h0, 32'h8, 32'h108);
        chk("lw_no_stall", {31'b0, stall}, 32'd0);
        tick();
        set_id(1'b1, C_ADD, 5'd5, 5'd6, 5'd7, 32'hAA, 32'hBB, 32'h0, 32'h10C);
        chk("lu_rs_stall", {31'b0, stall}, 32'd1);
        tick();
        chk("bubble_valid", {31'b0, ex_valid}, 32'd0);
        chk("bubble_ctrl", {19'b0, ex_ctrl}, 32'd0);
        chk("bubble_rt_hold", {27'b0, ex_rt}, 32'd5);
        chk("bubble_rdata1_hold", ex_rdata1, 32'h30);
        chk("bubble_cnt_1", {28'b0, bubble_cnt}, 32'd1);
        chk("stall_one_cycle", {31'b0, stall}, 32'd0);
        tick();
        chk("add_valid", {31'b0, ex_valid}, 32'd1);
        chk("add_ctrl", {19'b0, ex_ctrl}, {19'b0, C_ADD});
        chk("add_rd", {27'b0, ex_rd}, 32'd7);
        chk("add_rdata1", ex_rdata1, 32'hAA);
        chk("bubble_cnt_still_1", {28'b0, bubble_cnt}, 32'd1);

        // no false stall: immediate with rt as destination
        set_id(1'b1, C_LW, 5'd1, 5'd5, 5'd0, 32'h40, 32'h0, 32'h0, 32'h110);
        tick();
        set_id(1'b1, C_ADDI, 5'd3, 5'd5, 5'd0, 32'h1, 32'h2, 32'h3, 32'h114);
        chk("addi_rt_dest_no_stall", {31'b0, stall}, 32'd0);
        set_id(1'b1, C_SW, 5'd3, 5'd5, 5'd0, 32'h1, 32'h2, 32'h3, 32'h114);
        chk("sw_rt_src_stall", {31'b0, stall}, 32'd1);
        set_id(1'b0, C_SW, 5'd3, 5'd5, 5'd0, 32'h1, 32'h2, 32'h3, 32'h114);
        chk("invalid_id_no_stall", {31'b0, stall}, 32'd0);
        tick();
        chk("invalid_load_valid", {31'b0, ex_valid}, 32'd0);
        chk("invalid_load_ctrl", {19'b0, ex_ctrl}, 32'd0);
        chk("invalid_load_rdata2", ex_rdata2, 32'h2);

        // lw to $0 never stalls
        set_id(1'b1, C_LW, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h118);
        tick();
        set_id(1'b1, C_ADD, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'h0, 32'h11C);
        chk("lw_r0_no_stall", {31'b0, stall}, 32'd0);
        tick();

        // flush wins over hazard
        set_id(1'b1, C_LW, 5'd1, 5'd5, 5'd0, 32'h50, 32'h0, 32'h0, 32'h120);
        tick();
        set_id(1'b1, C_ADD, 5'd5, 5'd6, 5'd7, 32'h0, 32'h0, 32'h0, 32'h124);
        flush = 1'b1;
        #1;
        chk("flush_masks_stall", {31'b0, stall}, 32'd0);
        tick();
        flush = 1'b0;
        chk("flush_valid", {31'b0, ex_valid}, 32'd0);
        chk("flush_ctrl", {19'b0, ex_ctrl}, 32'd0);
        chk("flush_cnt_1", {28'b0, flush_cnt}, 32'd1);
        chk("flush_bubble_unchanged", {28'b0, bubble_cnt}, 32'd1);

        // self-dependent loads alternate load/bubble: 20 bubbles in 40 cycles
        set_id(1'b1, C_LW, 5'd5, 5'd5, 5'd0, 32'h60, 32'h0, 32'h0, 32'h128);
        for (int i = 0; i < 40; i++) tick();
        chk("bubble_saturated", {28'b0, bubble_cnt}, 32'hF);
        for (int i = 0; i < 4; i++) tick();
        chk("bubble_stays_saturated", {28'b0, bubble_cnt}, 32'hF);
        chk("flush_cnt_kept", {28'b0, flush_cnt}, 32'd1);

        // reset during a stall cycle
        tick();
        chk("pre_reset_stall", {31'b0, stall}, 32'd1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_valid", {31'b0, ex_valid}, 32'd0);
        chk("mid_rst_ctrl", {19'b0, ex_ctrl}, 32'd0);
        chk("mid_rst_rt", {27'b0, ex_rt}, 32'd0);
        chk("mid_rst_rdata1", ex_rdata1, 32'd0);
        chk("mid_rst_pc4", ex_pc4, 32'd0);
        chk("mid_rst_bubble_cnt", {28'b0, bubble_cnt}, 32'd0);
        chk("mid_rst_flush_cnt", {28'b0, flush_cnt}, 32'd0);
        chk("mid_rst_stall", {31'b0, stall}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
